// File: rtl/ram_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_pkg
// Purpose  : Shared types and default sizes for the RAM-backed streaming FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package ram_fifo_pkg;

    localparam int c_default_addr_width = 23;
    localparam int c_default_data_width = 16;

    // Owner of the single RAM port in a given cycle
    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_READ  = 2'd1,
        GRANT_WRITE = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/ram_fifo_obuf.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_obuf
// Purpose  : Two-entry registered prefetch buffer hiding the RAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module ram_fifo_obuf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = i_pop & (r_count != 2'd0);
    // A push into a full buffer is only possible alongside a pop
    assign w_push = i_push & (w_pop | (r_count != 2'd2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_push_data;
                    else                 r_tail <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl
// Purpose  : Deep streaming FIFO built on a single-port synchronous-read RAM.
// Revision : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = c_default_addr_width,
    parameter int DATA_WIDTH = c_default_data_width
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   fill,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [ADDR_WIDTH:0] c_depth = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_count;
    grant_e                r_last_grant;
    logic                  r_rd_pend;
    // Holds the arbiter off until reset_n has been sampled high at an edge
    logic                  r_run;

    logic [1:0]            w_obuf_count;
    logic                  w_wr_req;
    logic                  w_rd_req;
    grant_e                w_grant;

    always_comb begin
        w_wr_req = r_run & in_valid & (r_mem_count < c_depth) & ~flush;
        w_rd_req = r_run & (r_mem_count != '0)
                 & ((w_obuf_count + {1'b0, r_rd_pend}) < 2'd2) & ~flush;
        w_grant  = GRANT_NONE;
        // Reads win unless the previous grant was also a read, so both streams alternate
        if (w_rd_req && (!w_wr_req || r_last_grant == GRANT_WRITE)) begin
            w_grant = GRANT_READ;
        end else if (w_wr_req) begin
            w_grant = GRANT_WRITE;
        end
    end

    assign in_ready = (w_grant == GRANT_WRITE);
    assign mem_we   = (w_grant == GRANT_WRITE);
    assign mem_addr = (w_grant == GRANT_WRITE) ? r_wr_ptr : r_rd_ptr;
    assign mem_din  = (w_grant == GRANT_WRITE) ? in_data : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_mem_count  <= '0;
            r_last_grant <= GRANT_WRITE;
            r_rd_pend    <= 1'b0;
            r_run        <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (flush) begin
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_mem_count  <= '0;
                r_last_grant <= GRANT_WRITE;
                r_rd_pend    <= 1'b0;
            end else begin
                r_rd_pend <= (w_grant == GRANT_READ);
                case (w_grant)
                    GRANT_WRITE: begin
                        r_wr_ptr     <= r_wr_ptr + ADDR_WIDTH'(1);
                        r_mem_count  <= r_mem_count + (ADDR_WIDTH+1)'(1);
                        r_last_grant <= GRANT_WRITE;
                    end
                    GRANT_READ: begin
                        r_rd_ptr     <= r_rd_ptr + ADDR_WIDTH'(1);
                        r_mem_count  <= r_mem_count - (ADDR_WIDTH+1)'(1);
                        r_last_grant <= GRANT_READ;
                    end
                    default: ;
                endcase
            end
        end
    end

    ram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_flush     (flush),
        .i_push      (r_rd_pend),
        .i_push_data (mem_dout),
        .i_pop       (out_ready),
        .o_head      (out_data),
        .o_count     (w_obuf_count)
    );

    assign out_valid = (w_obuf_count != 2'd0);
    assign fill      = r_mem_count
                     + {{ADDR_WIDTH{1'b0}}, r_rd_pend}
                     + {{(ADDR_WIDTH-1){1'b0}}, w_obuf_count};

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_fifo_ctrl
// Purpose  : Self-checking bench for ram_fifo_ctrl with a 16-word RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   fill;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .fill      (fill),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Single-port synchronous-read sample RAM
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO of accepted words; fill must equal words accepted minus emitted
    logic [DW-1:0] q[$];
    bit            mon_en = 1'b0;
    bit            prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    int            n_emit = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("fill_vs_model", 32'(fill), 32'(q.size()));
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                n_emit++;
                if (q.size() == 0) check("emit_without_data", 32'(out_data), 32'hFFFF_FFFF);
                else               check("order", 32'(out_data), 32'(q.pop_front()));
            end
            if (in_valid && in_ready) q.push_back(in_data);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        q.delete();
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic drain(input string name);
        int c;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            if (fill == '0 && !out_valid) break;
            c++;
        end
        check(name, 32'(fill), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic write_n(input int n, input logic [DW-1:0] base);
        int acc = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 100 && acc < n; c++) begin
            in_data = base + DW'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("write_n_accepted", 32'(acc), 32'(n));
    endtask

    typedef struct packed {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic [AW:0]   e_fill;
        logic          e_we;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int acc;
        int emit0;
        int sent;
        int c;
        bit prev_we;
        int win_acc;
        int win_emit;

        vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd0, 1'b1};
        vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0};
        vecs[2]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0000, 5'd1, 1'b1};
        vecs[3]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 16'h1111, 5'd2, 1'b0};
        vecs[4]  = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 16'h1111, 5'd2, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1111, 5'd3, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111, 5'd3, 1'b0};
        vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h2222, 5'd2, 1'b0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd1, 1'b0};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h3333, 5'd1, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0};

        // Reset state with a pending input word
        in_valid  = 1'b1;
        in_data   = 16'hABCD;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        release_reset();

        // Cycle-by-cycle vectors from an empty FIFO
        for (int i = 0; i < 11; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].id;
            out_ready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
            check($sformatf("vec%0d_fill", i), 32'(fill), 32'(vecs[i].e_fill));
            check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Capacity: RAM plus two prefetched words
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            in_data = DW'(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check("cap_accepted", 32'(acc), 32'(DEPTH + 2));
        @(negedge clk);
        check("cap_fill", 32'(fill), 32'(DEPTH + 2));
        check("cap_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        emit0 = n_emit;
        drain("cap_drain");
        check("cap_emitted", 32'(n_emit - emit0), 32'(DEPTH + 2));

        // 40 words continuous in/out, pointers wrap twice
        emit0 = n_emit;
        sent = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 300 && sent < 40; k++) begin
            in_data = 16'h0500 + DW'(sent);
            @(negedge clk);
            if (in_ready) sent++;
            @(posedge clk); #1;
        end
        check("wrap_sent", 32'(sent), 32'd40);
        drain("wrap_drain");
        check("wrap_emitted", 32'(n_emit - emit0), 32'd40);

        // Both streams busy with data stored: strict alternation
        out_ready = 1'b0;
        write_n(4, 16'h0A00);
        repeat (6) @(posedge clk);
        #1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        win_acc   = 0;
        win_emit  = 0;
        prev_we   = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            in_data = 16'h0B00 + DW'(k);
            @(negedge clk);
            if (k >= 4) begin
                check("alt_toggle", 32'(mem_we), 32'(!prev_we));
                if (in_valid && in_ready) win_acc++;
                if (out_valid && out_ready) win_emit++;
            end
            prev_we = mem_we;
            @(posedge clk); #1;
        end
        check("alt_accepts", 32'(win_acc), 32'd10);
        check("alt_emits", 32'(win_emit), 32'd10);
        drain("alt_drain");

        // Random handshakes over a 1000-word ramp
        emit0 = n_emit;
        sent = 0;
        for (int k = 0; k < 20000 && sent < 1000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'(sent);
            out_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        check("rand_sent", 32'(sent), 32'd1000);
        drain("rand_drain");
        check("rand_emitted", 32'(n_emit - emit0), 32'd1000);

        // Flush with a read in flight
        out_ready = 1'b0;
        write_n(5, 16'h0C00);
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        mon_en   = 1'b0;
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(negedge clk);
        check("pre_flush_fill", 32'(fill), 32'd4);
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        check("post_flush_out_valid", 32'(out_valid), 32'd0);
        check("post_flush_fill", 32'(fill), 32'd0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            if (out_valid) break;
            c++;
        end
        check("flush_first_valid", 32'(out_valid), 32'd1);
        check("flush_first_data", 32'(out_data), 32'h0000_BEEF);
        @(posedge clk); #1;
        drain("flush_drain");

        // Reset mid-stream: 10 written, 3 read
        out_ready = 1'b0;
        write_n(10, 16'h0D00);
        emit0 = n_emit;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && (n_emit - emit0) < 3; k++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("mid_read3", 32'(n_emit - emit0), 32'd3);
        mon_en   = 1'b0;
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_din", 32'(mem_din), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_fill", 32'(fill), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        release_reset();
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b1;
        @(negedge clk);
        check("mid_fill_after_release", 32'(fill), 32'd0);
        check("mid_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("lat_t%0d_out_valid", k), 32'(out_valid), 32'(k == 3));
            if (k == 3) check("lat_out_data", 32'(out_data), 32'h0000_1234);
            @(posedge clk); #1;
        end
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
